hit_array_framer: RTL and testbench
===================================

# hit_array_framer

Transmit-side framer for the hit-array link. Accepts one event per handshake, consisting of two 38-bit block hit arrays (row 0, row 1). Emits each event as a fixed-length stream of 16-bit words toward the SFP serializer: header word 16'hAAAA, a sequence word, then six payload words. The far-end joint/cluster logic locks onto that header and reconstructs both arrays.

## Interface
- ARRAY_W, 38: width of each hit array.
- HEADER, 16'hAAAA: frame header word.
- IDLE_WORD, 16'h0000: fill word driven while no frame is in flight.
- clk  input  1  system clock; everything is synchronous to its rising edge.
- rst  input  1  synchronous, active-high reset.
- array_in0  input  38  row-0 hit array, sampled on accept.
- array_in1  input  38  row-1 hit array, sampled on accept.
- in_valid  input  1  event available.
- in_ready  output  1  framer can accept an event.
- tx_word  output  16  current link word.
- tx_valid  output  1  tx_word is a frame word.
- tx_ready  input  1  serializer consumes tx_word this cycle.
- frame_busy  output  1  a frame is in flight (state != IDLE).

## Operation
- Accept occurs when in_valid && in_ready. Both arrays are latched into holding registers at that edge.
- States:
  - IDLE: in_ready=1. Goes to HDR on accept.
  - HDR: word = HEADER.
  - SEQ: word = seq_cnt.
  - PAY: idx 0..5.
  - CHK: present only when configured.
  - After the last word, return to IDLE.
- A state advances only on a cycle where tx_valid && tx_ready.
- Payload order:
  - idx0 = a0[15:0]
  - idx1 = a0[31:16]
  - idx2 = {10'b0, a0[37:32]}
  - idx3 = a1[15:0]
  - idx4 = a1[31:16]
  - idx5 = {10'b0, a1[37:32]}
- Bits 37 and 0 of each array are transmitted unchanged, even though downstream logic ignores them.
- seq_cnt is 16 bits. It increments by 1 when the final word of a frame is consumed and wraps 16'hFFFF -> 16'h0000.
- Backpressure: while tx_valid && !tx_ready, tx_word and state stay unchanged.
- Outside frames: tx_valid=0 and tx_word=IDLE_WORD.
- Header aliasing: payload words may legally equal 16'hAAAA; no escaping. Receivers use the sequence word and frame length for alignment.
- Reset values:
  - in_ready=0 during the reset cycle, then 1.
  - tx_word=IDLE_WORD, tx_valid=0, frame_busy=0.
  - seq_cnt=0, holding registers=0, state=IDLE.
- Reset mid-frame: the frame is truncated with no trailer. The next frame starts with seq 0.
- in_valid asserted while busy is ignored; the source must hold it until accepted.

## Timing
- All outputs are registered.
- Accept at edge N puts the header on tx_word with tx_valid=1 from cycle N+1.
- With tx_ready tied high:
  - Frame occupies 8 consecutive cycles, or 9 with checksum.
  - in_ready returns the cycle after the last word.
  - Minimum header-to-header spacing is 10 cycles (11 with checksum): one idle cycle for the accept, plus one IDLE_WORD cycle.
- Holding registers are stable for the whole frame, so a new array_in value during a frame does not affect it.
- in_ready depends only on state, never combinationally on tx_ready.

## Configuration
- HIT_FRAMER_CHECKSUM_EN defined:
  - CHK word appended after idx5.
  - Value = XOR of the seq word and payload words idx0..idx5; the header is excluded.
  - Frame length 9.
- Not defined: CHK state and accumulator are absent; frame length 8.

## Structure
- Package hit_frame_pkg holds:
  - ARRAY_W, HEADER, IDLE_WORD, PAYLOAD_WORDS=6.
  - FRAME_LEN derived from HIT_FRAMER_CHECKSUM_EN.
  - State encoding: IDLE, HDR, SEQ, PAY, CHK.
  - The shared word-slice function, reused by the receiver.
- Sub-module hit_frame_checksum:
  - 16-bit XOR accumulator with clear/enable.
  - Instantiated only under HIT_FRAMER_CHECKSUM_EN.

## Test plan
- Basic frame, tx_ready=1, first frame after reset:
  - Stimulus: a0=38'h20_0000_0006, a1=38'h00_0001_8000.
  - Required words: AAAA, 0000, 0006, 0000, 0020, 8000, 0001, 0000.
  - Checksum build additionally ends with word 80_27.
- Backpressure:
  - Stimulus: tx_ready low for 3 cycles at idx2.
  - Required: tx_word held at 16'h0020 (for the basic-frame data) with tx_valid=1; the sequence otherwise matches an unstalled run.
- Sequence wrap:
  - Stimulus: preload 65535 frames, or force seq_cnt=16'hFFFF, then send 2 frames.
  - Required: seq words are FFFF, then 0000.
- Busy input:
  - Stimulus: change array_in0 and hold in_valid=1 during a frame.
  - Required: the current frame's payload is unchanged; the new arrays are accepted exactly 1 cycle after the last word.
- Reset at word 4 of a frame:
  - Required: next cycle tx_valid=0 and tx_word=0000.
  - The next frame's seq word is 0000.
- Loopback:
  - Stimulus: feed tx_word into the receiving joint block, using a0 bit i and a1 bit i+1 set.
  - Required: the joined output arrays contain the expected bridging bits.

Source files
------------

// File: rtl/hit_frame_pkg.sv
// -----------------------------------------------------------------------------
// hit_frame_pkg
// Shared constants, state encoding and word-slice helper for the hit-array
// link. The transmit framer (hit_array_framer) and the far-end receiver both
// import this package so that the payload word order is defined in one place.
//
// Optional feature macro: HIT_FRAMER_CHECKSUM_EN
//   defined   -> frames carry a trailing XOR check word (FRAME_LEN = 9)
//   undefined -> no check word                          (FRAME_LEN = 8)
// -----------------------------------------------------------------------------
package hit_frame_pkg;

    localparam int          ARRAY_W       = 38;
    localparam logic [15:0] HEADER        = 16'hAAAA;
    localparam logic [15:0] IDLE_WORD     = 16'h0000;
    localparam int          PAYLOAD_WORDS = 6;

`ifdef HIT_FRAMER_CHECKSUM_EN
    // header + sequence + payload + check word
    localparam int          FRAME_LEN     = PAYLOAD_WORDS + 3;
`else
    // header + sequence + payload
    localparam int          FRAME_LEN     = PAYLOAD_WORDS + 2;
`endif

    // Index of the last payload word inside the PAY state.
    localparam logic [2:0]  LAST_PAY_IDX  = 3'(PAYLOAD_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_SEQ  = 3'd2,
        ST_PAY  = 3'd3,
        ST_CHK  = 3'd4
    } frame_state_t;

    // Payload word idx of an event. Each 38-bit row is split low-to-high into
    // two full 16-bit words plus a 6-bit remainder, row 0 first. All bits,
    // including bit 0 and bit 37, travel unchanged.
    function automatic logic [15:0] hit_word_slice(
        input logic [ARRAY_W-1:0] a0,
        input logic [ARRAY_W-1:0] a1,
        input logic [2:0]         idx
    );
        logic [15:0] w;
        w = IDLE_WORD;
        case (idx)
            3'd0:    w = a0[15:0];
            3'd1:    w = a0[31:16];
            3'd2:    w = {10'b0, a0[37:32]};
            3'd3:    w = a1[15:0];
            3'd4:    w = a1[31:16];
            3'd5:    w = {10'b0, a1[37:32]};
            default: w = IDLE_WORD;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/hit_frame_checksum.sv
// -----------------------------------------------------------------------------
// hit_frame_checksum
// 16-bit XOR accumulator for the optional frame check word. Only built when
// HIT_FRAMER_CHECKSUM_EN is defined; the default build has no accumulator.
//
// Ports:
//   clk  in   1   system clock
//   rst  in   1   synchronous active-high reset
//   clr  in   1   restart accumulation (start of a new frame)
//   en   in   1   fold din into the running value this cycle
//   din  in  16   word being folded in
//   sum  out 16   registered running XOR
// -----------------------------------------------------------------------------
`ifdef HIT_FRAMER_CHECKSUM_EN
module hit_frame_checksum (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] din,
    output logic [15:0] sum
);

    logic [15:0] r_acc;

    // clr has priority over en: a clear and an accumulate never coincide
    // inside the framer, but a clear must always win if they did.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_acc <= 16'h0000;
        end else if (en) begin
            r_acc <= r_acc ^ din;
        end
    end

    assign sum = r_acc;

endmodule
`endif

// File: rtl/hit_array_framer.sv
// -----------------------------------------------------------------------------
// hit_array_framer
// Transmit-side framer for the hit-array link. One accepted event (two 38-bit
// hit arrays) becomes a fixed-length frame of 16-bit words:
//   HEADER, seq_cnt, six payload words [, XOR check word]
// Optional feature macro: HIT_FRAMER_CHECKSUM_EN (appends the check word).
//
// Ports:
//   clk         in   1   system clock, rising edge
//   rst         in   1   synchronous active-high reset
//   array_in0   in  38   row-0 hit array, captured on accept
//   array_in1   in  38   row-1 hit array, captured on accept
//   in_valid    in   1   event available
//   in_ready    out  1   framer can accept an event (registered, state only)
//   tx_word     out 16   current link word (IDLE_WORD outside frames)
//   tx_valid    out  1   tx_word is a frame word
//   tx_ready    in   1   serializer consumes tx_word this cycle
//   frame_busy  out  1   a frame is in flight
//   dbg_state   out  3   FSM state (frame_state_t encoding)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Once valid is raised it stays high with its data unchanged until
// that transfer; ready may change freely and never depends combinationally on
// the other side's valid.
// -----------------------------------------------------------------------------
module hit_array_framer
    import hit_frame_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [ARRAY_W-1:0] array_in0,
    input  logic [ARRAY_W-1:0] array_in1,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [15:0]        tx_word,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               frame_busy,
    output logic [2:0]         dbg_state
);

    frame_state_t       r_state;
    frame_state_t       w_state_next;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_next;
    logic [ARRAY_W-1:0] r_hold0;
    logic [ARRAY_W-1:0] r_hold1;
    logic [15:0]        r_seq;
    logic [15:0]        r_tx_word;
    logic [15:0]        w_tx_word_next;
    logic               r_tx_valid;
    logic               w_tx_valid_next;
    logic               r_in_ready;
    logic               w_accept;
    logic               w_advance;
    logic               w_seq_inc;

    assign w_accept  = (r_state == ST_IDLE) && r_in_ready && in_valid;
    assign w_advance = r_tx_valid && tx_ready;

`ifdef HIT_FRAMER_CHECKSUM_EN
    logic        w_chk_en;
    logic [15:0] w_chk_sum;
    logic [15:0] w_chk_word;

    // Fold every word leaving SEQ or PAY; the header never enters the sum.
    assign w_chk_en = w_advance && ((r_state == ST_SEQ) || (r_state == ST_PAY));

    hit_frame_checksum u_checksum (
        .clk (clk),
        .rst (rst),
        .clr (w_accept),
        .en  (w_chk_en),
        .din (r_tx_word),
        .sum (w_chk_sum)
    );

    // The check word is loaded on the same edge that consumes idx5, so the
    // idx5 word is folded in here rather than waiting for the register.
    assign w_chk_word = w_chk_sum ^ r_tx_word;
`endif

    // Next-state and next-output logic. Outputs are registered from the
    // next-state values so the word for a state is on the link the cycle the
    // state is entered.
    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_tx_word_next  = r_tx_word;
        w_tx_valid_next = r_tx_valid;
        w_seq_inc       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx_word_next  = IDLE_WORD;
                w_tx_valid_next = 1'b0;
                if (w_accept) begin
                    w_state_next    = ST_HDR;
                    w_tx_word_next  = HEADER;
                    w_tx_valid_next = 1'b1;
                end
            end

            ST_HDR: begin
                if (w_advance) begin
                    w_state_next   = ST_SEQ;
                    w_tx_word_next = r_seq;
                end
            end

            ST_SEQ: begin
                if (w_advance) begin
                    w_state_next   = ST_PAY;
                    w_idx_next     = 3'd0;
                    w_tx_word_next = hit_word_slice(r_hold0, r_hold1, 3'd0);
                end
            end

            ST_PAY: begin
                if (w_advance) begin
                    if (r_idx == LAST_PAY_IDX) begin
`ifdef HIT_FRAMER_CHECKSUM_EN
                        w_state_next   = ST_CHK;
                        w_tx_word_next = w_chk_word;
`else
                        w_state_next    = ST_IDLE;
                        w_tx_word_next  = IDLE_WORD;
                        w_tx_valid_next = 1'b0;
                        w_seq_inc       = 1'b1;
`endif
                    end else begin
                        w_idx_next     = r_idx + 3'd1;
                        w_tx_word_next = hit_word_slice(r_hold0, r_hold1, w_idx_next);
                    end
                end
            end

`ifdef HIT_FRAMER_CHECKSUM_EN
            ST_CHK: begin
                if (w_advance) begin
                    w_state_next    = ST_IDLE;
                    w_tx_word_next  = IDLE_WORD;
                    w_tx_valid_next = 1'b0;
                    w_seq_inc       = 1'b1;
                end
            end
`endif

            default: begin
                w_state_next    = ST_IDLE;
                w_tx_word_next  = IDLE_WORD;
                w_tx_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= 3'd0;
            r_hold0    <= '0;
            r_hold1    <= '0;
            r_seq      <= 16'h0000;
            r_tx_word  <= IDLE_WORD;
            r_tx_valid <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_tx_word  <= w_tx_word_next;
            r_tx_valid <= w_tx_valid_next;
            // Decoded from the registered state one cycle late: after a frame
            // the link shows one IDLE_WORD cycle before the next accept can be
            // taken, and ready drops on the accepting edge itself.
            r_in_ready <= (r_state == ST_IDLE) && !w_accept;
            if (w_accept) begin
                r_hold0 <= array_in0;
                r_hold1 <= array_in1;
            end
            if (w_seq_inc) begin
                r_seq <= r_seq + 16'd1;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign tx_word    = r_tx_word;
    assign tx_valid   = r_tx_valid;
    assign frame_busy = (r_state != ST_IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_hit_array_framer.sv
module tb_hit_array_framer;
    import hit_frame_pkg::*;

`ifdef HIT_FRAMER_CHECKSUM_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [37:0] array_in0 = '0;
    logic [37:0] array_in1 = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] tx_word;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        frame_busy;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    hit_array_framer dut (
        .clk        (clk),
        .rst        (rst),
        .array_in0  (array_in0),
        .array_in1  (array_in1),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx_word    (tx_word),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .frame_busy (frame_busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [15:0] rx_q[$];
    logic [15:0] exp_q[$];
    int          hdr_q[$];
    logic        prev_hdr = 1'b0;

    always @(posedge clk) cyc++;

    // Words consumed by the serializer, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) rx_q.push_back(tx_word);
        if (!rst && tx_valid && (dbg_state == ST_HDR) && !prev_hdr) hdr_q.push_back(cyc);
        prev_hdr = !rst && tx_valid && (dbg_state == ST_HDR);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input string tag);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_in_ready"}, in_ready, 1);
    endtask

    task automatic send_event(input string tag, input logic [37:0] a0, input logic [37:0] a1);
        @(posedge clk); #1;
        array_in0 = a0;
        array_in1 = a1;
        in_valid  = 1'b1;
        wait_ready(tag);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_words(input string tag, input int n);
        int t = 0;
        while (rx_q.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_wordcount"}, (rx_q.size() >= n), 1);
    endtask

    // Expected frame from the link format: header, seq, rows split low-first.
    task automatic build_exp(input logic [37:0] a0, input logic [37:0] a1, input logic [15:0] seq);
        logic [15:0] chk;
        exp_q.delete();
        exp_q.push_back(16'hAAAA);
        exp_q.push_back(seq);
        exp_q.push_back(a0[15:0]);
        exp_q.push_back(a0[31:16]);
        exp_q.push_back({10'b0, a0[37:32]});
        exp_q.push_back(a1[15:0]);
        exp_q.push_back(a1[31:16]);
        exp_q.push_back({10'b0, a1[37:32]});
        chk = 16'h0000;
        for (int k = 1; k < 8; k++) chk ^= exp_q[k];
        if (FLEN == 9) exp_q.push_back(chk);
    endtask

    task automatic check_words(input string tag);
        logic [15:0] got;
        wait_words(tag, FLEN);
        for (int k = 0; k < FLEN; k++) begin
            got = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hDEAD;
            check_eq($sformatf("%s_w%0d", tag, k), got, exp_q[k]);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [37:0] basic_a0 = 38'h20_0000_0006;
    logic [37:0] basic_a1 = 38'h00_0001_8000;
    logic [15:0] basic_words[9] = '{16'hAAAA, 16'h0000, 16'h0006, 16'h0000,
                                    16'h0020, 16'h8000, 16'h0001, 16'h0000, 16'h8027};
    logic [15:0] exp_seq = 16'h0000;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int lb_bits[4] = '{0, 15, 31, 36};
        logic [15:0] w[9];
        logic [37:0] a0, a1, r0, r1;

        // Reset state
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_tx_word", tx_word, 16'h0000);
        check_eq("rst_frame_busy", frame_busy, 0);
        check_eq("rst_state", dbg_state, ST_IDLE);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("post_rst_in_ready", in_ready, 1);

        // Basic frame, hand-computed words
        rx_q.delete();
        send_event("basic", basic_a0, basic_a1);
        exp_q.delete();
        for (int k = 0; k < FLEN; k++) exp_q.push_back(basic_words[k]);
        check_words("basic");
        exp_seq = 16'h0001;
        repeat (2) @(negedge clk);
        check_eq("basic_after_valid", tx_valid, 0);
        check_eq("basic_after_word", tx_word, 16'h0000);
        check_eq("basic_after_busy", frame_busy, 0);

        // Backpressure: stall 3 cycles on idx2
        rx_q.delete();
        send_event("bp", basic_a0, basic_a1);
        t = 0;
        @(posedge clk); #1;
        while (!(tx_valid && dbg_state == ST_PAY && tx_word == 16'h0020) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        tx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("bp_hold_word%0d", k), tx_word, 16'h0020);
            check_eq($sformatf("bp_hold_valid%0d", k), tx_valid, 1);
            @(posedge clk);
        end
        #1 tx_ready = 1'b1;
        build_exp(basic_a0, basic_a1, exp_seq);
        check_words("bp");
        exp_seq++;

        // Busy input: change arrays mid-frame with in_valid held, spacing
        rx_q.delete();
        hdr_q.delete();
        @(posedge clk); #1;
        array_in0 = 38'h15_5555_AAAA;
        array_in1 = 38'h2A_AAAA_5555;
        in_valid  = 1'b1;
        wait_ready("busy_a");
        @(posedge clk); #1;
        array_in0 = 38'h01_DEAD_BEEF;
        array_in1 = 38'h3F_0F0F_F0F0;
        wait_ready("busy_b");
        @(posedge clk); #1;
        in_valid = 1'b0;
        build_exp(38'h15_5555_AAAA, 38'h2A_AAAA_5555, exp_seq);
        check_words("busy_a");
        exp_seq++;
        build_exp(38'h01_DEAD_BEEF, 38'h3F_0F0F_F0F0, exp_seq);
        check_words("busy_b");
        exp_seq++;
        check_eq("busy_hdr_count", hdr_q.size(), 2);
        if (hdr_q.size() >= 2) check_eq("busy_hdr_spacing", hdr_q[1] - hdr_q[0], FLEN + 2);

        // Sequence wrap
        repeat (3) @(posedge clk);
        #1 force dut.r_seq = 16'hFFFF;
        @(posedge clk); #1;
        release dut.r_seq;
        rx_q.delete();
        send_event("wrap0", 38'h00_0000_0001, 38'h20_0000_0000);
        build_exp(38'h00_0000_0001, 38'h20_0000_0000, 16'hFFFF);
        check_words("wrap0");
        send_event("wrap1", 38'h00_0000_0001, 38'h20_0000_0000);
        build_exp(38'h00_0000_0001, 38'h20_0000_0000, 16'h0000);
        check_words("wrap1");
        exp_seq = 16'h0001;

        // Reset at word 4 (idx2) of a frame
        rx_q.delete();
        send_event("rstmid", 38'h3F_1234_5678, 38'h00_0000_0000);
        t = 0;
        @(posedge clk); #1;
        while (!(tx_valid && dbg_state == ST_PAY && tx_word == 16'h003F) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("rstmid_reached_w4", tx_word, 16'h003F);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rstmid_tx_valid", tx_valid, 0);
        check_eq("rstmid_tx_word", tx_word, 16'h0000);
        check_eq("rstmid_busy", frame_busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        rx_q.delete();
        send_event("rstmid_next", basic_a0, basic_a1);
        exp_q.delete();
        for (int k = 0; k < FLEN; k++) exp_q.push_back(basic_words[k]);
        check_words("rstmid_next");
        exp_seq = 16'h0001;

        // Loopback: rebuild both rows from the link words
        for (int n = 0; n < 4; n++) begin
            a0 = 38'd1 << lb_bits[n];
            a1 = 38'd1 << (lb_bits[n] + 1);
            rx_q.delete();
            send_event("loop", a0, a1);
            wait_words("loop", FLEN);
            for (int k = 0; k < FLEN; k++) w[k] = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hDEAD;
            r0 = {w[4][5:0], w[3], w[2]};
            r1 = {w[7][5:0], w[6], w[5]};
            check_eq($sformatf("loop%0d_seq", lb_bits[n]), w[1], exp_seq);
            check_eq($sformatf("loop%0d_a0", lb_bits[n]), r0, a0);
            check_eq($sformatf("loop%0d_a1", lb_bits[n]), r1, a1);
            check_eq($sformatf("loop%0d_bridge", lb_bits[n]), {r0[lb_bits[n]], r1[lb_bits[n] + 1]}, 2'b11);
            check_eq($sformatf("loop%0d_pad", lb_bits[n]), {w[4][15:6], w[7][15:6]}, 20'h0);
            exp_seq++;
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
